// File: rtl/conv_output_collector.sv
// conv_output_collector
// Receive-side companion to the 2.5D convolution layer. Re-aligns the pixel
// valid with the layer's sum output, tracks raster position to drop sums from
// windows that are not fully inside the image, and requantizes each surviving
// 32-bit sum to a signed 8-bit pixel (round, saturate, optional ReLU).

module conv_output_collector #(
  parameter int NUM_TREES    = 2,
  parameter int IMG_WIDTH    = 4,
  parameter int IMG_HEIGHT   = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int PIPE_LATENCY = 5,
  parameter int SHIFT        = 8,
  parameter int RELU         = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pixel_valid_in,
  input  logic [32*NUM_TREES-1:0]  conv_vector_in,
  output logic [8*NUM_TREES-1:0]   pixel_vector_out,
  output logic                     pixel_valid_out,
  output logic                     frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

  // Rounding constant 2^(SHIFT-1) in the widened 33-bit domain.
  localparam logic signed [32:0] ROUND = 33'sd1 <<< (SHIFT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Clamp a shifted sum to signed 8 bits; ReLU (when enabled) zeroes negatives.
  function automatic logic [7:0] sat8(input logic signed [32:0] v);
    logic [7:0] res;
    if ((RELU != 0) && (v < 33'sd0)) begin
      res = 8'h00;
    end else if (v > 33'sd127) begin
      res = 8'h7F;
    end else if (v < -33'sd128) begin
      res = 8'h80;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

  logic [PIPE_LATENCY-1:0]  r_vdly;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  state_t                   r_state;
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic signed [32:0]       r_s1_data [NUM_TREES];

  logic                     w_sample_valid;
  logic                     w_keep;
  logic                     w_at_end;
  logic                     w_last;
  logic signed [32:0]       w_s1_next [NUM_TREES];
  logic [8*NUM_TREES-1:0]   w_s2_next;

  assign w_sample_valid = r_vdly[PIPE_LATENCY-1];
  assign w_keep   = w_sample_valid && (r_col >= COL_FIRST) && (r_row >= ROW_FIRST);
  assign w_at_end = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_last   = w_keep && w_at_end;

  // Delay pixel_valid_in by the convolution latency so it lines up with its sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vdly <= '0;
    end else begin
      r_vdly[0] <= pixel_valid_in;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_vdly[i] <= r_vdly[i-1];
      end
    end
  end

  // Raster position of the sample currently on conv_vector_in; frozen on gaps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_sample_valid) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Controller: records the class of the last accepted sample; returns to IDLE
  // once a frame has ended and no new sample follows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sample_valid) begin
            r_state <= w_keep ? ST_STREAM : ST_FILL;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (w_sample_valid) begin
            r_state <= w_keep ? ST_STREAM : ST_FILL;
          end else if ((r_col == '0) && (r_row == '0)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage-1 arithmetic: round and arithmetic-shift each lane in 33 bits.
  always_comb begin
    for (int i = 0; i < NUM_TREES; i++) begin
      w_s1_next[i] = ($signed({conv_vector_in[32*i+31], conv_vector_in[32*i +: 32]}) + ROUND) >>> SHIFT;
    end
  end

  // Stage-2 arithmetic: saturate each lane to signed 8 bits.
  always_comb begin
    w_s2_next = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      w_s2_next[8*i +: 8] = sat8(r_s1_data[i]);
    end
  end

  // Stage-1 register: shifted sums with their keep and last flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < NUM_TREES; i++) begin
        r_s1_data[i] <= '0;
      end
    end else begin
      r_s1_valid <= w_keep;
      r_s1_last  <= w_last;
      if (w_keep) begin
        for (int i = 0; i < NUM_TREES; i++) begin
          r_s1_data[i] <= w_s1_next[i];
        end
      end
    end
  end

  // Stage-2 register: saturated pixel vector, its valid, and the frame-end pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_vector_out <= '0;
      pixel_valid_out  <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      if (r_s1_valid) begin
        pixel_vector_out <= w_s2_next;
      end
      pixel_valid_out <= r_s1_valid;
      frame_done      <= r_s1_valid && r_s1_last;
    end
  end

endmodule
